// File: rtl/boot_cmd_table_if.sv
`default_nettype none
// ============================================================================
// Module      : boot_cmd_table_if
// Description : Bus bundle for the boot command table: controller fetch port,
//               host write stream, host readback and status/error flags.
//               slave = the table, master = host/controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface boot_cmd_table_if #(
  parameter int AW = 10,
  parameter int DW = 29
);
  // Controller fetch port
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_cmd;
  logic          mc_busy;
  // Host control and write stream
  logic          clr;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW:0]   wr_ptr;
  // Host readback
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  // Status
  logic          clearing;
  logic          err_lock;
  logic          err_full;

  modport slave (
    input  boot_addr, mc_busy, clr, wr_valid, wr_data, rd_addr,
    output boot_cmd, wr_ready, wr_ptr, rd_data, clearing, err_lock, err_full
  );

  modport master (
    output boot_addr, mc_busy, clr, wr_valid, wr_data, rd_addr,
    input  boot_cmd, wr_ready, wr_ptr, rd_data, clearing, err_lock, err_full
  );
endinterface
`default_nettype wire

// File: rtl/boot_cmd_table.sv
`default_nettype none
// ============================================================================
// Module      : boot_cmd_table
// Description : 2^AW x DW command table for the motor controller boot fetch.
//               Self-clears to zero after reset and on request, accepts a
//               host write stream, and offers a registered readback port.
//               Entry layout: [28:15] delay, [14:12] phase, [11:0] PWM.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_cmd_table #(
  parameter int AW = 10,
  parameter int DW = 29
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  boot_cmd_table_if.slave bus
);

  localparam int            c_DEPTH     = 1 << AW;
  localparam logic [AW-1:0] c_LAST_ADDR = {AW{1'b1}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_addr;
  logic [AW:0]   r_wr_ptr;
  logic          r_err_lock;
  logic          r_err_full;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_mem [c_DEPTH];

  logic          w_clearing;
  logic          w_full;
  logic          w_wr_ready;
  logic          w_wr_fire;

  assign w_clearing = (r_state == S_CLEAR);
  // Bit AW of the pointer is the saturated "table full" flag.
  assign w_full     = r_wr_ptr[AW];
  // A same-cycle clr blocks the write so an accepted clear drops it cleanly.
  assign w_wr_ready = ~w_clearing & ~bus.mc_busy & ~w_full & ~bus.clr;
  assign w_wr_fire  = bus.wr_valid & w_wr_ready;

  // Control FSM: clear sweep, write pointer and sticky error flags.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_wr_ptr   <= '0;
      r_err_lock <= 1'b0;
      r_err_full <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (bus.clr) begin
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == c_LAST_ADDR) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (bus.clr && bus.mc_busy) begin
            r_err_lock <= 1'b1;
          end else if (bus.clr) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_err_lock <= 1'b0;
            r_err_full <= 1'b0;
          end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end else if (bus.wr_valid && bus.mc_busy) begin
            r_err_lock <= 1'b1;
          end else if (bus.wr_valid && w_full) begin
            r_err_full <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  // Table storage: zero sweep while clearing, host writes otherwise; no reset.
  always_ff @(posedge HCLK) begin
    if (w_clearing) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  // Registered host readback, held at zero while the table is being cleared.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_clearing ? '0 : r_mem[bus.rd_addr];
    end
  end

  // Controller fetch is a plain asynchronous read, independent of mc_busy.
  assign bus.boot_cmd = w_clearing ? '0 : r_mem[bus.boot_addr];
  assign bus.wr_ready = w_wr_ready;
  assign bus.wr_ptr   = r_wr_ptr;
  assign bus.rd_data  = r_rd_data;
  assign bus.clearing = w_clearing;
  assign bus.err_lock = r_err_lock;
  assign bus.err_full = r_err_full;

endmodule
`default_nettype wire

// File: tb/tb_boot_cmd_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_cmd_table
// Description : Self-checking bench for boot_cmd_table. A behavioural table
//               model is compared against the DUT on every falling edge, and
//               directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_cmd_table;

  localparam int AW    = 10;
  localparam int DW    = 29;
  localparam int DEPTH = 1024;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  boot_cmd_table_if #(.AW(AW), .DW(DW)) bus ();

  boot_cmd_table #(.AW(AW), .DW(DW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr      = 0;
  bit            m_clearing = 1'b1;
  int            m_left     = DEPTH;
  bit            m_elock    = 1'b0;
  bit            m_efull    = 1'b0;
  logic [DW-1:0] m_rd       = '0;

  // Clear = DEPTH cycles of "all outputs zero", after which the whole table is zero.
  initial begin
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        m_clearing = 1'b1;
        m_left     = DEPTH;
        m_ptr      = 0;
        m_elock    = 1'b0;
        m_efull    = 1'b0;
        m_rd       = '0;
      end else begin
        m_rd = m_clearing ? '0 : m_mem[bus.rd_addr];
        if (m_clearing) begin
          if (bus.clr) m_left = DEPTH;
          else         m_left = m_left - 1;
          if (m_left == 0) begin
            m_clearing = 1'b0;
            foreach (m_mem[i]) m_mem[i] = '0;
          end
        end else if (bus.clr && bus.mc_busy) begin
          m_elock = 1'b1;
        end else if (bus.clr) begin
          m_clearing = 1'b1;
          m_left     = DEPTH;
          m_ptr      = 0;
          m_elock    = 1'b0;
          m_efull    = 1'b0;
        end else if (bus.wr_valid && !bus.mc_busy && m_ptr < DEPTH) begin
          m_mem[m_ptr] = bus.wr_data;
          m_ptr        = m_ptr + 1;
        end else if (bus.wr_valid && bus.mc_busy) begin
          m_elock = 1'b1;
        end else if (bus.wr_valid) begin
          m_efull = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [DW-1:0] e_cmd;
  logic          e_rdy;

  initial begin
    forever begin
      @(negedge HCLK);
      e_cmd = m_clearing ? '0 : m_mem[bus.boot_addr];
      e_rdy = !m_clearing && !bus.mc_busy && (m_ptr < DEPTH) && !bus.clr;
      check("m_clearing", 32'(bus.clearing), 32'(m_clearing));
      check("m_wr_ready", 32'(bus.wr_ready), 32'(e_rdy));
      check("m_wr_ptr",   32'(bus.wr_ptr),   32'(m_ptr));
      check("m_boot_cmd", 32'(bus.boot_cmd), 32'(e_cmd));
      check("m_rd_data",  32'(bus.rd_data),  32'(m_rd));
      check("m_err_lock", 32'(bus.err_lock), 32'(m_elock));
      check("m_err_full", 32'(bus.err_full), 32'(m_efull));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Counts falling edges with clearing high; optionally re-pulses clr after restart_at of them.
  task automatic measure_clear(input int restart_at, output int n);
    n = 0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge HCLK);
      if (!bus.clearing) break;
      n++;
      if (n == restart_at) begin
        bus.clr = 1'b1;
        @(posedge HCLK);
        #1 bus.clr = 1'b0;
      end
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    @(posedge HCLK);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge HCLK);
    #1 bus.clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clearing"}, 32'(bus.clearing), 32'd1);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
    check({tag, "_wr_ptr"},   32'(bus.wr_ptr),   32'd0);
    check({tag, "_boot_cmd"}, 32'(bus.boot_cmd), 32'd0);
    check({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    check({tag, "_err_lock"}, 32'(bus.err_lock), 32'd0);
    check({tag, "_err_full"}, 32'(bus.err_full), 32'd0);
  endtask

  logic [AW-1:0] probe [4] = '{10'd0, 10'd1, 10'd511, 10'd1023};
  logic [DW-1:0] ent1;
  logic [DW-1:0] ent_last;
  int            n;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.boot_addr = '0;
    bus.mc_busy   = 1'b0;
    bus.clr       = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    ent1     = {14'd50, 3'd2, 12'h100};
    ent_last = {14'd1023, 3'd5, 12'h3FF};

    // 1. Reset values, then the power-on clear.
    repeat (2) @(negedge HCLK);
    check_reset_vals("rst");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    measure_clear(0, n);
    check("t1_clear_len", 32'(n), 32'd1024);
    check("t1_wr_ready", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK);
      #1 bus.boot_addr = probe[i];
      @(negedge HCLK);
      check("t1_boot_zero", 32'(bus.boot_cmd), 32'd0);
    end

    // 2. Stream three entries and read them back.
    @(posedge HCLK);
    #1;
    push({14'd100, 3'd1, 12'h200});
    push({14'd50,  3'd2, 12'h100});
    push({14'd0,   3'd0, 12'h000});
    @(negedge HCLK);
    check("t2_wr_ptr", 32'(bus.wr_ptr), 32'd3);
    @(posedge HCLK);
    #1 bus.boot_addr = 10'd0;
    @(negedge HCLK);
    check("t2_boot0", 32'(bus.boot_cmd), 32'h0032_1200);
    @(posedge HCLK);
    #1 bus.boot_addr = 10'd1;
    bus.rd_addr = 10'd1;
    @(negedge HCLK);
    check("t2_boot1", 32'(bus.boot_cmd), 32'(ent1));
    @(negedge HCLK);
    check("t2_rd1", 32'(bus.rd_data), 32'(ent1));

    // 3. Lock: clr and write while the controller is busy.
    @(posedge HCLK);
    #1 bus.mc_busy = 1'b1;
    bus.boot_addr = 10'd3;
    pulse_clr();
    @(negedge HCLK);
    check("t3_lock_clr", 32'(bus.err_lock), 32'd1);
    check("t3_not_clear", 32'(bus.clearing), 32'd0);
    @(posedge HCLK);
    #1 bus.wr_data = 29'h1ABC_DEF;
    bus.wr_valid = 1'b1;
    @(negedge HCLK);
    check("t3_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(posedge HCLK);
    #1 bus.wr_valid = 1'b0;
    bus.mc_busy = 1'b0;
    @(negedge HCLK);
    check("t3_wr_ptr", 32'(bus.wr_ptr), 32'd3);
    check("t3_entry3", 32'(bus.boot_cmd), 32'd0);

    // 4. Fill to full, then one more write.
    @(posedge HCLK);
    #1;
    for (int k = 3; k < DEPTH; k++) begin
      bus.wr_data  = {14'(k), 3'd5, 12'(k)};
      bus.wr_valid = 1'b1;
      @(posedge HCLK);
      #1;
    end
    bus.wr_data = 29'h0FFF_FFFF;
    bus.boot_addr = 10'd0;
    @(negedge HCLK);
    check("t4_wr_ptr", 32'(bus.wr_ptr), 32'd1024);
    check("t4_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(posedge HCLK);
    #1 bus.wr_valid = 1'b0;
    @(negedge HCLK);
    check("t4_err_full", 32'(bus.err_full), 32'd1);
    check("t4_entry0", 32'(bus.boot_cmd), 32'h0032_1200);
    @(posedge HCLK);
    #1 bus.boot_addr = 10'd1023;
    @(negedge HCLK);
    check("t4_entry_last", 32'(bus.boot_cmd), 32'(ent_last));

    // 5. Clear with a restart 300 cycles in.
    @(posedge HCLK);
    #1;
    pulse_clr();
    measure_clear(300, n);
    check("t5_clear_len", 32'(n), 32'd1324);
    check("t5_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    check("t5_err_lock", 32'(bus.err_lock), 32'd0);
    check("t5_err_full", 32'(bus.err_full), 32'd0);
    check("t5_boot_zero", 32'(bus.boot_cmd), 32'd0);

    // 6a. Async reset while idle with state present.
    @(posedge HCLK);
    #1;
    push(29'h0ABC_DEF);
    push(29'h0123_456);
    bus.mc_busy = 1'b1;
    push(29'h0000_001);
    bus.mc_busy = 1'b0;
    bus.boot_addr = 10'd0;
    bus.rd_addr   = 10'd0;
    @(negedge HCLK);
    check("t6_pre_ptr", 32'(bus.wr_ptr), 32'd2);
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    #1 check_reset_vals("t6a");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    measure_clear(0, n);
    check("t6a_clear_len", 32'(n), 32'd1024);

    // 6b. Async reset 500 cycles into a clear.
    @(posedge HCLK);
    #1;
    pulse_clr();
    repeat (500) @(negedge HCLK);
    #1 HRESETn = 1'b0;
    #1 check_reset_vals("t6b");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    measure_clear(0, n);
    check("t6b_clear_len", 32'(n), 32'd1024);

    // Table usable again afterwards.
    @(posedge HCLK);
    #1;
    push(29'h1555_5555);
    @(negedge HCLK);
    check("t6_post_entry", 32'(bus.boot_cmd), 32'h1555_5555);
    repeat (3) @(negedge HCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
